// File: rtl/eu_issue.sv
// eu_issue: register file plus a three-state issue sequencer that hands operands to an external EU
// and writes its result back, with direct loads and a debug read port.
module eu_issue #(
  parameter int N = 16,
  parameter int NREG = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  instr,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic         ld_en,
  input  logic [3:0]   ld_addr,
  input  logic [N-1:0] ld_data,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic         Ci,
  output logic [1:0]   f0,
  output logic [3:0]   rd,
  output logic         eu_valid,
  input  logic [N-1:0] eu_res,
  output logic         done,
  output logic         err,
  input  logic [3:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;
  state_t state;
  logic [N-1:0] regs [NREG];
  logic div0;
  logic unused_rsvd;
  assign unused_rsvd = instr[0];
  assign instr_ready = state == IDLE && !ld_en;
  assign dbg_data = regs[dbg_addr];
  assign div0 = f0 == 2'b11 && B == '0;
  // Operands are captured at accept, so a write to rd never disturbs the issued A/B.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      A <= '0;
      B <= '0;
      Ci <= 1'b0;
      f0 <= 2'b00;
      rd <= 4'd0;
      eu_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err <= 1'b0;
          if (ld_en) regs[ld_addr] <= ld_data;
          else if (instr_valid) begin
            A <= regs[instr[9:6]];
            B <= regs[instr[5:2]];
            Ci <= instr[1];
            f0 <= instr[15:14];
            rd <= instr[13:10];
            eu_valid <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!div0) regs[rd] <= eu_res;
          eu_valid <= 1'b0;
          done <= 1'b1;
          err <= div0;
          state <= WB;
        end
        WB: begin
          done <= 1'b0;
          err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eu_issue.sv
// tb_eu_issue: directed scenarios plus randomized traffic against a transaction-level model
// that tracks each instruction by the number of cycles since it was accepted.
module tb_eu_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic instr_valid = 1'b0;
  logic ld_en = 1'b0;
  logic [3:0] ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [3:0] dbg_addr = '0;
  logic [15:0] eu_res;
  logic instr_ready, Ci, eu_valid, done, err;
  logic [15:0] A, B, dbg_data;
  logic [1:0] f0;
  logic [3:0] rd;
  int vectors = 0;
  int errors = 0;

  logic [15:0] m_regs [16];
  logic [15:0] n_regs [16];
  logic [15:0] m_A, m_B, n_A, n_B;
  logic m_Ci, n_Ci, m_ev, n_ev, m_done, n_done, m_err, n_err;
  logic [1:0] m_f0, n_f0;
  logic [3:0] m_rd, n_rd;
  int m_age, n_age;

  eu_issue #(.N(16), .NREG(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .A(A), .B(B), .Ci(Ci), .f0(f0), .rd(rd), .eu_valid(eu_valid), .eu_res(eu_res),
    .done(done), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] eu_fn(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b, input logic ci);
    case (f)
      2'd0: eu_fn = a + b + {15'd0, ci};
      2'd1: eu_fn = a - b - {15'd0, ci};
      2'd2: eu_fn = a * b;
      default: eu_fn = (b == 0) ? 16'd0 : a / b;
    endcase
  endfunction

  // The bench plays the EU, computing the result from what the model says was issued.
  assign eu_res = eu_fn(m_f0, m_A, m_B, m_Ci);

  function automatic logic [15:0] enc(input logic [1:0] f, input int d, input int s1, input int s2, input logic ci);
    enc = {f, 4'(d), 4'(s1), 4'(s2), ci, 1'b0};
  endfunction

  task automatic model_edge();
    logic bz;
    n_regs = m_regs;
    {n_A, n_B, n_Ci, n_f0, n_rd, n_ev, n_done, n_err, n_age} = {m_A, m_B, m_Ci, m_f0, m_rd, m_ev, m_done, m_err, m_age};
    if (!rst_n) begin
      foreach (n_regs[i]) n_regs[i] = '0;
      {n_A, n_B, n_Ci, n_f0, n_rd, n_ev, n_done, n_err} = '0;
      n_age = 0;
    end else if (m_age == 0) begin
      n_done = 1'b0;
      n_err = 1'b0;
      if (ld_en) n_regs[ld_addr] = ld_data;
      else if (instr_valid) begin
        n_A = m_regs[instr[9:6]];
        n_B = m_regs[instr[5:2]];
        n_Ci = instr[1];
        n_f0 = instr[15:14];
        n_rd = instr[13:10];
        n_ev = 1'b1;
        n_age = 1;
      end
    end else if (m_age == 1) begin
      bz = m_f0 == 2'd3 && m_B == 0;
      if (!bz) n_regs[m_rd] = eu_fn(m_f0, m_A, m_B, m_Ci);
      n_ev = 1'b0;
      n_done = 1'b1;
      n_err = bz;
      n_age = 2;
    end else begin
      n_done = 1'b0;
      n_err = 1'b0;
      n_age = 0;
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    m_regs = n_regs;
    {m_A, m_B, m_Ci, m_f0, m_rd, m_ev, m_done, m_err, m_age} = {n_A, n_B, n_Ci, n_f0, n_rd, n_ev, n_done, n_err, n_age};
  endtask

  task automatic load(input int a, input logic [15:0] d);
    ld_en = 1'b1;
    ld_addr = 4'(a);
    ld_data = d;
    cyc();
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ld_en = 1'b1;
    ld_addr = 4'd2;
    ld_data = 16'hBEEF;
    cyc();
    cyc();
    ld_en = 1'b0;
    rst_n = 1'b1;
    dbg_addr = 4'd2;
    #1;
    vectors++;
    if ({A, B, Ci, f0, rd, eu_valid, done, err, instr_ready, dbg_data} !== {32'd0, 1'b0, 2'd0, 4'd0, 3'b000, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL reset: got A=%h B=%h ci=%b f0=%h rd=%h ev=%b done=%b err=%b rdy=%b dbg=%h, want zeros rdy=1",
               A, B, Ci, f0, rd, eu_valid, done, err, instr_ready, dbg_data);
    end
  endtask

  task automatic test_add();
    load(1, 16'd5);
    load(2, 16'd3);
    instr = enc(2'd0, 3, 1, 2, 1'b0);
    instr_valid = 1'b1;
    #1;
    vectors++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", instr_ready); end
    cyc();
    instr_valid = 1'b0;
    vectors++;
    if ({eu_valid, done, A, B, f0, rd} !== {1'b1, 1'b0, 16'd5, 16'd3, 2'd0, 4'd3}) begin
      errors++;
      $display("FAIL add_issue: got ev=%b done=%b A=%h B=%h f0=%h rd=%h want 1 0 0005 0003 0 3", eu_valid, done, A, B, f0, rd);
    end
    cyc();
    vectors++;
    if ({eu_valid, done, err} !== 3'b010) begin errors++; $display("FAIL add_wb: got ev/done/err=%b want 010", {eu_valid, done, err}); end
    dbg_addr = 4'd3;
    #1;
    vectors++;
    if (dbg_data !== 16'h0008) begin errors++; $display("FAIL add_result: got %h want 0008", dbg_data); end
    cyc();
    vectors++;
    if ({done, instr_ready} !== 2'b01) begin errors++; $display("FAIL add_idle: got done/rdy=%b want 01", {done, instr_ready}); end
  endtask

  task automatic test_div_zero();
    instr = enc(2'd3, 4, 1, 0, 1'b0);
    instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
    cyc();
    vectors++;
    if ({done, err} !== 2'b11) begin errors++; $display("FAIL div0_flags: got done/err=%b want 11", {done, err}); end
    dbg_addr = 4'd4;
    #1;
    vectors++;
    if (dbg_data !== 16'h0000) begin errors++; $display("FAIL div0_nowrite: got %h want 0000", dbg_data); end
    cyc();
    vectors++;
    if ({done, err} !== 2'b00) begin errors++; $display("FAIL div0_pulse: got done/err=%b want 00", {done, err}); end
  endtask

  task automatic test_back_to_back();
    instr = enc(2'd0, 8, 1, 2, 1'b1);
    instr_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      vectors++;
      if (instr_ready !== (k % 3 == 0)) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, instr_ready, k % 3 == 0); end
      cyc();
    end
    instr_valid = 1'b0;
    dbg_addr = 4'd8;
    #1;
    vectors++;
    if (dbg_data !== 16'd9) begin errors++; $display("FAIL b2b_result: got %h want 0009", dbg_data); end
  endtask

  task automatic test_ld_priority();
    ld_en = 1'b1;
    ld_addr = 4'd5;
    ld_data = 16'h1234;
    instr = enc(2'd0, 6, 5, 5, 1'b0);
    instr_valid = 1'b1;
    #1;
    vectors++;
    if (instr_ready !== 1'b0) begin errors++; $display("FAIL ldpri_ready: got %b want 0", instr_ready); end
    cyc();
    ld_en = 1'b0;
    dbg_addr = 4'd5;
    #1;
    vectors++;
    if ({instr_ready, eu_valid, dbg_data} !== {2'b10, 16'h1234}) begin
      errors++;
      $display("FAIL ldpri_load: got rdy=%b ev=%b r5=%h want 1 0 1234", instr_ready, eu_valid, dbg_data);
    end
    cyc();
    instr_valid = 1'b0;
    vectors++;
    if ({eu_valid, A} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL ldpri_issue: got ev=%b A=%h want 1 1234", eu_valid, A); end
    ld_en = 1'b1;
    ld_addr = 4'd6;
    ld_data = 16'hDEAD;
    cyc();
    cyc();
    ld_en = 1'b0;
    dbg_addr = 4'd6;
    #1;
    vectors++;
    if (dbg_data !== 16'h2468) begin errors++; $display("FAIL ldpri_ignored: got r6=%h want 2468", dbg_data); end
  endtask

  task automatic test_sub_alias();
    load(1, 16'd2);
    load(2, 16'd3);
    instr = enc(2'd1, 1, 1, 2, 1'b0);
    instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
    vectors++;
    if ({A, B} !== {16'd2, 16'd3}) begin errors++; $display("FAIL alias_operands: got A=%h B=%h want 0002 0003", A, B); end
    cyc();
    cyc();
    dbg_addr = 4'd1;
    #1;
    vectors++;
    if ({dbg_data, A} !== {16'hFFFF, 16'd2}) begin errors++; $display("FAIL alias_result: got r1=%h A=%h want ffff 0002", dbg_data, A); end
  endtask

  task automatic test_reset_mid();
    instr = enc(2'd2, 7, 1, 2, 1'b0);
    instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
    vectors++;
    if (eu_valid !== 1'b1) begin errors++; $display("FAIL rstmid_issue: got ev=%b want 1", eu_valid); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({A, B, Ci, f0, rd, eu_valid, done, err, instr_ready} !== {32'd0, 1'b0, 2'd0, 4'd0, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_outputs: got A=%h B=%h ci=%b f0=%h rd=%h ev=%b done=%b err=%b rdy=%b want zeros rdy=1",
               A, B, Ci, f0, rd, eu_valid, done, err, instr_ready);
    end
    for (int r = 0; r < 16; r++) begin
      dbg_addr = 4'(r);
      #1;
      vectors++;
      if (dbg_data !== 16'd0) begin errors++; $display("FAIL rstmid_reg[%0d]: got %h want 0000", r, dbg_data); end
    end
  endtask

  task automatic test_random();
    logic [42:0] got, exp;
    for (int k = 0; k < 400; k++) begin
      rst_n = $urandom_range(0, 59) != 0;
      ld_en = $urandom_range(0, 3) == 0;
      ld_addr = 4'($urandom);
      ld_data = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      instr_valid = $urandom_range(0, 1) == 1;
      instr = 16'($urandom);
      dbg_addr = 4'($urandom);
      #1;
      got = {A, B, Ci, f0, rd, eu_valid, done, err, instr_ready};
      exp = {m_A, m_B, m_Ci, m_f0, m_rd, m_ev, m_done, m_err, m_age == 0 && !ld_en};
      vectors++;
      if (got !== exp) begin errors++; $display("FAIL rand_outputs[%0d]: got %h want %h", k, got, exp); end
      vectors++;
      if (dbg_data !== m_regs[dbg_addr]) begin errors++; $display("FAIL rand_dbg[%0d]: r%0d got %h want %h", k, dbg_addr, dbg_data, m_regs[dbg_addr]); end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_div_zero();
    test_back_to_back();
    test_ld_priority();
    test_sub_alias();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
